// File: rtl/layer_pkg.sv
// Shared types for the Layer classifier path.
package layer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } argmax_state_e;

endpackage

// File: rtl/layer_argmax.sv
// Sequential argmax over one packed vector of signed elements.
// One signed compare per cycle; valid/ready handshake on both sides.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no vector held, in_ready=1
// ST_SCAN | walking elements 1..N-1 of the captured vector
// ST_DONE | result presented on out_*; may hand off to a new vector
module layer_argmax
   import layer_pkg::*;
#(
   parameter  int N          = 4,
   parameter  int DATA_WIDTH = 8,
   localparam int IDX_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_vec,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IDX_WIDTH-1:0]    out_idx,
   output logic [DATA_WIDTH-1:0]   out_max,
   output logic                    out_tie
);

   argmax_state_e state, state_nxt;

   logic signed [DATA_WIDTH-1:0] in_elems [N];
   logic signed [DATA_WIDTH-1:0] vec_q    [N];
   logic signed [DATA_WIDTH-1:0] best_val;
   logic signed [DATA_WIDTH-1:0] cur_elem;
   logic [IDX_WIDTH-1:0]         best_idx;
   logic [IDX_WIDTH-1:0]         scan_idx;
   logic                         tie_q;
   logic                         accept;
   logic                         last_elem;

   always_comb begin
      for (int j = 0; j < N; j++) begin
         in_elems[j] = in_vec[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign cur_elem  = vec_q[scan_idx];
   assign last_elem = (scan_idx == IDX_WIDTH'(N - 1));

   assign out_valid = (state == ST_DONE);
   assign out_idx   = best_idx;
   assign out_max   = best_val;
   assign out_tie   = tie_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt = (N == 1) ? ST_DONE : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (last_elem) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  state_nxt = (N == 1) ? ST_DONE : ST_SCAN;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Lowest index wins on equality; tie only clears when a strictly larger value appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < N; j++) begin
            vec_q[j] <= '0;
         end
         best_val <= '0;
         best_idx <= '0;
         tie_q    <= 1'b0;
         scan_idx <= '0;
      end else if (accept) begin
         for (int j = 0; j < N; j++) begin
            vec_q[j] <= in_elems[j];
         end
         best_val <= in_elems[0];
         best_idx <= '0;
         tie_q    <= 1'b0;
         scan_idx <= IDX_WIDTH'(1);
      end else if (state == ST_SCAN) begin
         if (cur_elem > best_val) begin
            best_val <= cur_elem;
            best_idx <= scan_idx;
            tie_q    <= 1'b0;
         end else if (cur_elem == best_val) begin
            tie_q    <= 1'b1;
         end
         scan_idx <= scan_idx + IDX_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_layer_argmax.sv
// Self-checking bench for layer_argmax (N=4, DATA_WIDTH=8): table vectors,
// random vectors against a reference model, and hand-written handshake/reset sequences.
module tb_layer_argmax;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_vec;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_idx;
   logic [DW-1:0]   out_max;
   logic            out_tie;

   int checks   = 0;
   int failures = 0;

   layer_argmax #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_max   (out_max),
      .out_tie   (out_tie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] vec;
      logic [31:0] post;
      logic [1:0]  idx;
      logic [7:0]  max;
      logic        tie;
   } vec_rec_t;

   vec_rec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
      logic [7:0] ea, eb, ec, ed;
      ea = a[7:0]; eb = b[7:0]; ec = c[7:0]; ed = d[7:0];
      return {ed, ec, eb, ea};
   endfunction

   // Reference: the maximum value, the first index holding it, and whether it recurs.
   task automatic ref_model(input logic [31:0] v, output logic [1:0] idx,
                            output logic [7:0] mx, output logic tie);
      int e [4];
      int best;
      int cnt;
      for (int i = 0; i < 4; i++) e[i] = int'($signed(v[i*8 +: 8]));
      best = -1000;
      for (int i = 0; i < 4; i++) if (e[i] > best) best = e[i];
      cnt = 0;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (e[i] == best) begin
            cnt++;
            idx = 2'(i);
         end
      end
      mx  = best[7:0];
      tie = (cnt > 1);
   endtask

   // Called just after a posedge with the DUT in IDLE; returns the edge count to out_valid.
   task automatic send_get(input logic [31:0] v, input logic [31:0] post,
                           output logic [1:0] idx, output logic [7:0] mx,
                           output logic tie, output int lat);
      in_vec   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_vec   = post;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      idx = out_idx;
      mx  = out_max;
      tie = out_tie;
   endtask

   task automatic run_rec(input string name, input vec_rec_t r, input logic do_ref);
      logic [1:0] idx, eidx;
      logic [7:0] mx, emx;
      logic       tie, etie;
      int         lat;
      eidx = r.idx; emx = r.max; etie = r.tie;
      if (do_ref) ref_model(r.vec, eidx, emx, etie);
      out_ready = 1'b1;
      send_get(r.vec, r.post, idx, mx, tie, lat);
      check({name, "_lat"}, 32'(lat), 32'd3);
      check({name, "_idx"}, 32'(idx), 32'(eidx));
      check({name, "_max"}, 32'(mx), 32'(emx));
      check({name, "_tie"}, 32'(tie), 32'(etie));
      @(posedge clk);
      #1;
      check({name, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [1:0] idx;
      logic [7:0] mx;
      logic       tie;
      int         lat;
      vec_rec_t   r;
      logic [1:0] h_idx;
      logic [7:0] h_max;
      logic       h_tie;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b1;

      #3;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_idx",       32'(out_idx),   32'd0);
      check("rst_max",       32'(out_max),   32'd0);
      check("rst_tie",       32'(out_tie),   32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      tbl.push_back('{pack4(3, -1, 7, 2),         32'h5a5a5a5a, 2'd2, 8'd7,    1'b0});
      tbl.push_back('{pack4(5, 9, 9, 1),          32'h0,        2'd1, 8'd9,    1'b1});
      tbl.push_back('{pack4(9, 9, 10, 0),         32'hffffffff, 2'd2, 8'd10,   1'b0});
      tbl.push_back('{pack4(-128, -3, -3, -50),   32'h7f7f7f7f, 2'd1, 8'hfd,   1'b1});
      tbl.push_back('{pack4(-128, -128, -128, -128), 32'h0,     2'd0, 8'h80,   1'b1});
      tbl.push_back('{pack4(0, 0, 0, 0), pack4(0, 0, 0, 100),   2'd0, 8'd0,    1'b1});
      tbl.push_back('{pack4(1, 2, 3, 127),        32'h0,        2'd3, 8'd127,  1'b0});
      tbl.push_back('{pack4(-1, -2, -3, -4),      32'h0,        2'd0, 8'hff,   1'b0});
      tbl.push_back('{pack4(-5, 6, -7, 6),        32'h0,        2'd1, 8'd6,    1'b1});

      foreach (tbl[k]) run_rec($sformatf("tbl%0d", k), tbl[k], 1'b0);

      for (int k = 0; k < 40; k++) begin
         r.vec  = $urandom;
         if (k % 4 == 0) r.vec[31:24] = r.vec[15:8];
         r.post = $urandom;
         r.idx  = '0; r.max = '0; r.tie = 1'b0;
         run_rec($sformatf("rnd%0d", k), r, 1'b1);
      end

      // Backpressure then same-edge handoff.
      out_ready = 1'b0;
      send_get(pack4(3, -1, 7, 2), 32'h0, idx, mx, tie, lat);
      check("bp_lat", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready),  32'd0);
         check("bp_hold",     {out_idx, out_max, out_tie}, {2'd2, 8'd7, 1'b0});
      end
      in_vec    = pack4(5, 9, 9, 1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("ho_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("ho_valid_drop", 32'(out_valid), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ho_lat", 32'(lat), 32'd3);
      check("ho_res", {out_idx, out_max, out_tie}, {2'd1, 8'd9, 1'b1});
      @(posedge clk);
      #1;

      // Reset while scanning discards the result.
      in_vec   = pack4(1, 2, 3, 4);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_res",   {out_idx, out_max, out_tie}, {2'd0, 8'd0, 1'b0});
      check("mrst_ready", 32'(in_ready),  32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("mrst_no_pulse", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_valid", 32'(out_valid), 32'd0);
      r = '{pack4(4, 3, 2, 1), 32'h0, 2'd0, 8'd4, 1'b0};
      run_rec("post_rst", r, 1'b0);

      h_idx = 2'd0; h_max = 8'd0; h_tie = 1'b0;
      ref_model(pack4(0, 0, 0, 100), h_idx, h_max, h_tie);
      check("ref_sanity_idx", 32'(h_idx), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
